hazard_ctrl_unit: RTL and testbench
===================================

# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 5-stage MIPS core, replacing the single-cycle load-use detector. Generates PC/IF-ID write enables, the ID/EX control-zeroing mux select, IF-ID and ID-EX flushes, and an EX hold. Handles three hazard classes:
- load-use stalls of configurable length;
- taken-branch flushes resolved in EX;
- multi-cycle EX operations (multiply/divide unit) with a start/done handshake.

## Interface
Parameters:
- REG_ADDR_W, 5, register specifier width
- LOAD_DELAY, 1, bubbles per load-use hazard; legal 1..15
- CNT_W, 16, width of the stall statistics counter (HAZARD_STATS_EN only)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- id_ex_mem_read  input  1  instruction in EX is a load
- id_ex_reg_rt  input  REG_ADDR_W  load destination register
- if_id_reg_rs  input  REG_ADDR_W  ID source register rs
- if_id_reg_rt  input  REG_ADDR_W  ID source register rt
- if_id_uses_rt  input  1  ID instruction reads rt (0 for I-type ALU ops/loads)
- branch_taken  input  1  branch/jump in EX resolved taken
- mdu_start  input  1  multi-cycle op entered EX this cycle (1-cycle pulse)
- mdu_done  input  1  multi-cycle unit result valid (1-cycle pulse)
- PCWrite  output  1  PC register enable
- IF_ID_Write  output  1  IF/ID register enable
- Mux_Select_Stall  output  1  zero ID/EX control signals (inject bubble)
- if_id_flush  output  1  clear IF/ID to NOP
- id_ex_flush  output  1  clear ID/EX to NOP
- ex_hold  output  1  freeze ID/EX and EX/MEM inputs; insert bubble into MEM
- stall_count  output  CNT_W  stall-cycle counter (HAZARD_STATS_EN only)

## Operation
- Load-use hit: id_ex_mem_read=1, id_ex_reg_rt!=0, and (id_ex_reg_rt==if_id_reg_rs or (if_id_uses_rt and id_ex_reg_rt==if_id_reg_rt)).
  - Register 0 never hazards.
- FSM states: RUN, LOAD_STALL, MDU_BUSY. Down-counter ld_cnt, 4 bits.
- RUN:
  - Default outputs: PCWrite=1, IF_ID_Write=1, all others 0.
  - Load-use hit: stall this cycle (PCWrite=0, IF_ID_Write=0, Mux_Select_Stall=1).
    - LOAD_DELAY=1: remain in RUN.
    - LOAD_DELAY>1: go to LOAD_STALL with ld_cnt=LOAD_DELAY-1.
  - branch_taken: if_id_flush=1, id_ex_flush=1, PCWrite=1, IF_ID_Write=1, Mux_Select_Stall=0.
  - mdu_start: go to MDU_BUSY. Outputs this cycle are RUN defaults.
- LOAD_STALL:
  - Stall outputs asserted. ld_cnt decrements each cycle.
  - Return to RUN in the cycle after ld_cnt reaches 1; total stall = LOAD_DELAY cycles.
  - Detection inputs are ignored here; the bubble already occupies EX.
  - branch_taken here (illegal; EX holds a bubble): abort to RUN next cycle, flush outputs as in RUN.
- MDU_BUSY:
  - PCWrite=0, IF_ID_Write=0, ex_hold=1, Mux_Select_Stall=0.
  - Load-use detection and branch_taken are ignored.
  - mdu_done: outputs this cycle are still the MDU_BUSY outputs; go to RUN next cycle.
- Priority within one cycle: reset > MDU_BUSY state > branch_taken > mdu_start > load-use hit.
- Branch outputs are combinational from inputs plus state. Stall outputs are combinational in RUN and state-decoded in other states.

## Timing
- While reset=1 (asynchronous):
  - state=RUN, ld_cnt=0, stall_count=0.
  - Outputs forced to PCWrite=0, IF_ID_Write=0, Mux_Select_Stall=1, if_id_flush=0, id_ex_flush=0, ex_hold=0.
- First cycle after reset release: RUN defaults.
- Load-use response: zero-cycle latency (same cycle as the hit).
- Reset mid-LOAD_STALL or mid-MDU_BUSY: immediate return to reset outputs; no pending stall survives.
- mdu_done in the same cycle as mdu_start: single-cycle op. Stay in RUN; no hold asserted.
- mdu_done in RUN with no pending op: ignored.
- mdu_start while in MDU_BUSY: ignored.

## Configuration
- HAZARD_STATS_EN defined:
  - stall_count increments on every cycle with PCWrite=0 outside reset.
  - Saturates at all-ones (no wrap).
  - Cleared only by reset.
- HAZARD_STATS_EN undefined: stall_count port and counter logic are absent. All other behaviour is identical.

## Test plan
- Reset asserted 3 cycles, then released, no hazards -> reset outputs during reset (PCWrite=0, Mux_Select_Stall=1); PCWrite=1, IF_ID_Write=1, Mux_Select_Stall=0 from the first cycle after release.
- LOAD_DELAY=3, load to $8 in EX, ID reads rs=$8 -> exactly 3 consecutive stall cycles, then RUN; repeat with rt=$8 and if_id_uses_rt=0 -> no stall; rt=$0 load -> no stall.
- branch_taken with a simultaneous load-use hit -> if_id_flush=1, id_ex_flush=1, PCWrite=1, Mux_Select_Stall=0, no LOAD_STALL entry.
- mdu_start at cycle 10, mdu_done at cycle 14 -> ex_hold=1 and PCWrite=0 on cycles 11-14, RUN defaults on cycle 15; branch_taken pulsed at cycle 12 has no effect.
- reset pulsed in the 2nd cycle of a LOAD_DELAY=4 stall -> reset outputs immediately; RUN defaults after release with no residual stall.
- HAZARD_STATS_EN, CNT_W=4, 20 forced stall cycles -> stall_count=15 (saturated); without the macro the bench compiles with stall_count unconnected.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
// ----------------
// Pipeline hazard controller for the 5-stage MIPS core. Decides, every cycle,
// whether the front end may advance, whether a bubble is injected into ID/EX,
// whether IF/ID and ID/EX are flushed after a taken branch, and whether EX is
// frozen while the multiply/divide unit works.
//
// Parameters:
//   REG_ADDR_W  register specifier width
//   LOAD_DELAY  bubbles per load-use hazard (1..15)
//   CNT_W       width of the stall statistics counter
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   id_ex_mem_read      EX instruction is a load
//   id_ex_reg_rt        load destination register
//   if_id_reg_rs/rt     ID source registers
//   if_id_uses_rt       ID instruction actually reads rt
//   branch_taken        branch/jump in EX resolved taken
//   mdu_start/mdu_done  multi-cycle unit handshake pulses
//   PCWrite, IF_ID_Write    front-end enables
//   Mux_Select_Stall        zero ID/EX control (bubble)
//   if_id_flush, id_ex_flush  flush to NOP
//   ex_hold             freeze EX while the MDU is busy
//   stall_count         saturating count of cycles with PCWrite=0
//
// Optional feature: define HAZARD_STATS_EN to build the stall_count port and
// its counter; without it the port and the counter do not exist.

module hazard_ctrl_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_DELAY = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] id_ex_reg_rt,
    input  logic [REG_ADDR_W-1:0] if_id_reg_rs,
    input  logic [REG_ADDR_W-1:0] if_id_reg_rt,
    input  logic                  if_id_uses_rt,
    input  logic                  branch_taken,
    input  logic                  mdu_start,
    input  logic                  mdu_done,
    output logic                  PCWrite,
    output logic                  IF_ID_Write,
    output logic                  Mux_Select_Stall,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_hold
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]      stall_count
`endif
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MDU_BUSY   = 2'd2
    } state_t;

    // The first bubble is produced while still in RUN, so the dedicated
    // stall state only has to cover the remaining LOAD_DELAY-1 cycles.
    localparam logic [3:0] LD_INIT = 4'(LOAD_DELAY - 1);

    // Elaboration-time guard against an out-of-range configuration.
    if (LOAD_DELAY < 1 || LOAD_DELAY > 15 || CNT_W < 1) begin : g_param_check
        $error("hazard_ctrl_unit: LOAD_DELAY must be 1..15 and CNT_W >= 1");
    end

    state_t     state, state_next;
    logic [3:0] ld_cnt, ld_cnt_next;
    logic       load_use_hit;

    // A load only hazards if it writes a real register that the ID stage
    // reads; rt counts only when the instruction genuinely sources it.
    assign load_use_hit = id_ex_mem_read && (id_ex_reg_rt != '0) &&
                          ((id_ex_reg_rt == if_id_reg_rs) ||
                           (if_id_uses_rt && (id_ex_reg_rt == if_id_reg_rt)));

    // State register and bubble down-counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= RUN;
            ld_cnt <= '0;
        end else begin
            state  <= state_next;
            ld_cnt <= ld_cnt_next;
        end
    end

    // Next-state and output decode. Reset is folded in here so the outputs
    // take their safe stall values the instant reset rises, not at a clock.
    always_comb begin
        state_next       = state;
        ld_cnt_next      = ld_cnt;
        PCWrite          = 1'b1;
        IF_ID_Write      = 1'b1;
        Mux_Select_Stall = 1'b0;
        if_id_flush      = 1'b0;
        id_ex_flush      = 1'b0;
        ex_hold          = 1'b0;

        if (reset) begin
            PCWrite          = 1'b0;
            IF_ID_Write      = 1'b0;
            Mux_Select_Stall = 1'b1;
            state_next       = RUN;
            ld_cnt_next      = '0;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (mdu_start) begin
                        // A done in the same cycle means a single-cycle op.
                        if (!mdu_done) begin
                            state_next = MDU_BUSY;
                        end
                    end else if (load_use_hit) begin
                        PCWrite          = 1'b0;
                        IF_ID_Write      = 1'b0;
                        Mux_Select_Stall = 1'b1;
                        if (LOAD_DELAY > 1) begin
                            state_next  = LOAD_STALL;
                            ld_cnt_next = LD_INIT;
                        end
                    end
                end

                LOAD_STALL: begin
                    if (branch_taken) begin
                        // EX should hold a bubble here; recover cleanly anyway.
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        state_next  = RUN;
                        ld_cnt_next = '0;
                    end else begin
                        PCWrite          = 1'b0;
                        IF_ID_Write      = 1'b0;
                        Mux_Select_Stall = 1'b1;
                        if (ld_cnt <= 4'd1) begin
                            state_next  = RUN;
                            ld_cnt_next = '0;
                        end else begin
                            ld_cnt_next = ld_cnt - 4'd1;
                        end
                    end
                end

                MDU_BUSY: begin
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    ex_hold     = 1'b1;
                    if (mdu_done) begin
                        state_next = RUN;
                    end
                end

                default: begin
                    state_next  = RUN;
                    ld_cnt_next = '0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating count of front-end stall cycles, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (!PCWrite && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit
// -------------------
// Directed bench for hazard_ctrl_unit. Three instances share one set of
// inputs and differ only in LOAD_DELAY (1, 3 and 4), so each stimulus step
// shows how the stall length scales. Outputs are packed as
// {PCWrite, IF_ID_Write, Mux_Select_Stall, if_id_flush, id_ex_flush, ex_hold}.

module tb_hazard_ctrl_unit;

    localparam logic [5:0] O_RUN   = 6'b110000;
    localparam logic [5:0] O_STALL = 6'b001000;
    localparam logic [5:0] O_RST   = 6'b001000;
    localparam logic [5:0] O_FLUSH = 6'b110110;
    localparam logic [5:0] O_HOLD  = 6'b000001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mem_read = 1'b0;
    logic [4:0] ex_rt = '0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       uses_rt = 1'b0;
    logic       br = 1'b0;
    logic       m_start = 1'b0;
    logic       m_done = 1'b0;

    wire [5:0] o1, o3, o4;
`ifdef HAZARD_STATS_EN
    wire [3:0] cnt1, cnt3, cnt4;
`endif

    int errors = 0;
    int checks = 0;

    // 10-unit clock; stimulus changes on the falling edge.
    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_DELAY(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset(reset), .id_ex_mem_read(mem_read), .id_ex_reg_rt(ex_rt),
        .if_id_reg_rs(id_rs), .if_id_reg_rt(id_rt), .if_id_uses_rt(uses_rt),
        .branch_taken(br), .mdu_start(m_start), .mdu_done(m_done),
        .PCWrite(o1[5]), .IF_ID_Write(o1[4]), .Mux_Select_Stall(o1[3]),
        .if_id_flush(o1[2]), .id_ex_flush(o1[1]), .ex_hold(o1[0])
`ifdef HAZARD_STATS_EN
        , .stall_count(cnt1)
`endif
    );

    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_DELAY(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .reset(reset), .id_ex_mem_read(mem_read), .id_ex_reg_rt(ex_rt),
        .if_id_reg_rs(id_rs), .if_id_reg_rt(id_rt), .if_id_uses_rt(uses_rt),
        .branch_taken(br), .mdu_start(m_start), .mdu_done(m_done),
        .PCWrite(o3[5]), .IF_ID_Write(o3[4]), .Mux_Select_Stall(o3[3]),
        .if_id_flush(o3[2]), .id_ex_flush(o3[1]), .ex_hold(o3[0])
`ifdef HAZARD_STATS_EN
        , .stall_count(cnt3)
`endif
    );

    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_DELAY(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .id_ex_mem_read(mem_read), .id_ex_reg_rt(ex_rt),
        .if_id_reg_rs(id_rs), .if_id_reg_rt(id_rt), .if_id_uses_rt(uses_rt),
        .branch_taken(br), .mdu_start(m_start), .mdu_done(m_done),
        .PCWrite(o4[5]), .IF_ID_Write(o4[4]), .Mux_Select_Stall(o4[3]),
        .if_id_flush(o4[2]), .id_ex_flush(o4[1]), .ex_hold(o4[0])
`ifdef HAZARD_STATS_EN
        , .stall_count(cnt4)
`endif
    );

    // One cycle of stimulus: drive on the falling edge, settle for 1 unit.
    task automatic applyStimulus(input logic rst_v, input logic mr,
                                 input logic [4:0] ert, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic ur,
                                 input logic b, input logic ms, input logic md);
        @(negedge clk);
        reset    = rst_v;
        mem_read = mr;
        ex_rt    = ert;
        id_rs    = rs;
        id_rt    = rt;
        uses_rt  = ur;
        br       = b;
        m_start  = ms;
        m_done   = md;
        #1;
    endtask

    task automatic idle(input logic rst_v);
        applyStimulus(rst_v, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs,
                               input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [5:0] e1,
                            input logic [5:0] e3, input logic [5:0] e4);
        checkOutput({tag, "/ld1"}, {2'b00, o1}, {2'b00, e1});
        checkOutput({tag, "/ld3"}, {2'b00, o3}, {2'b00, e3});
        checkOutput({tag, "/ld4"}, {2'b00, o4}, {2'b00, e4});
    endtask

    initial begin
        $display("[TB] start");

        // Reset held three cycles, then released with no hazards.
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            checkAll($sformatf("reset_hold%0d", i), O_RST, O_RST, O_RST);
        end
        idle(1'b0);
        checkAll("first_after_reset", O_RUN, O_RUN, O_RUN);

        // Load to $8 hazarding rs=$8; second cycle still shows a hit, which
        // only the LOAD_DELAY=1 instance (back in RUN) reacts to.
        applyStimulus(1'b0, 1'b1, 5'd8, 5'd8, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        checkAll("lu_c0", O_STALL, O_STALL, O_STALL);
        applyStimulus(1'b0, 1'b1, 5'd8, 5'd8, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        checkAll("lu_c1", O_STALL, O_STALL, O_STALL);
        idle(1'b0);
        checkAll("lu_c2", O_RUN, O_STALL, O_STALL);
        idle(1'b0);
        checkAll("lu_c3", O_RUN, O_RUN, O_STALL);
        idle(1'b0);
        checkAll("lu_c4", O_RUN, O_RUN, O_RUN);

        // rt match but the ID instruction does not read rt.
        applyStimulus(1'b0, 1'b1, 5'd8, 5'd9, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        checkAll("rt_unused", O_RUN, O_RUN, O_RUN);
        // Load to $0 never hazards.
        applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkAll("reg_zero", O_RUN, O_RUN, O_RUN);
        // Not a load: matching registers alone do nothing.
        applyStimulus(1'b0, 1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        checkAll("no_load", O_RUN, O_RUN, O_RUN);

        // Branch beats a simultaneous rt load-use hit; no stall state entered.
        applyStimulus(1'b0, 1'b1, 5'd8, 5'd3, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        checkAll("br_vs_lu", O_FLUSH, O_FLUSH, O_FLUSH);
        idle(1'b0);
        checkAll("br_vs_lu_next", O_RUN, O_RUN, O_RUN);

        // Branch arriving during a load stall aborts it.
        applyStimulus(1'b0, 1'b1, 5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        checkAll("ls_br_c0", O_STALL, O_STALL, O_STALL);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkAll("ls_br_c1", O_FLUSH, O_FLUSH, O_FLUSH);
        idle(1'b0);
        checkAll("ls_br_c2", O_RUN, O_RUN, O_RUN);

        // MDU op: start at "cycle 10", done at "cycle 14"; branch at 12 and a
        // load-use hit at 13 must be ignored, repeated start too.
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkAll("mdu_c10", O_RUN, O_RUN, O_RUN);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkAll("mdu_c11", O_HOLD, O_HOLD, O_HOLD);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkAll("mdu_c12_br", O_HOLD, O_HOLD, O_HOLD);
        applyStimulus(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkAll("mdu_c13_lu", O_HOLD, O_HOLD, O_HOLD);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkAll("mdu_c14_done", O_HOLD, O_HOLD, O_HOLD);
        idle(1'b0);
        checkAll("mdu_c15", O_RUN, O_RUN, O_RUN);

        // Single-cycle op and a stray done in RUN.
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkAll("mdu_single", O_RUN, O_RUN, O_RUN);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkAll("mdu_stray_done", O_RUN, O_RUN, O_RUN);
        idle(1'b0);
        checkAll("mdu_after_stray", O_RUN, O_RUN, O_RUN);

        // Reset pulsed asynchronously in the 2nd cycle of a load stall.
        applyStimulus(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkAll("rst_ls_c0", O_STALL, O_STALL, O_STALL);
        idle(1'b0);
        checkAll("rst_ls_c1", O_RUN, O_STALL, O_STALL);
        reset = 1'b1;
        #1;
        checkAll("rst_async", O_RST, O_RST, O_RST);
        idle(1'b1);
        checkAll("rst_held", O_RST, O_RST, O_RST);
        idle(1'b0);
        checkAll("rst_release", O_RUN, O_RUN, O_RUN);
        idle(1'b0);
        checkAll("rst_no_residual", O_RUN, O_RUN, O_RUN);

`ifdef HAZARD_STATS_EN
        // 20 forced stall cycles via one long MDU op saturate a 4-bit counter.
        idle(1'b1);
        checkOutput("cnt_reset", {4'd0, cnt1}, 8'd0);
        idle(1'b0);
        applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("cnt_start", {4'd0, cnt1}, 8'd0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0,
                          (i == 19) ? 1'b1 : 1'b0);
            if (i == 5) begin
                checkOutput("cnt_partial", {4'd0, cnt3}, 8'd5);
            end
        end
        idle(1'b0);
        checkAll("cnt_run_after", O_RUN, O_RUN, O_RUN);
        checkOutput("cnt_sat_ld1", {4'd0, cnt1}, 8'd15);
        checkOutput("cnt_sat_ld4", {4'd0, cnt4}, 8'd15);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
